// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus widths, exception codes and CP0 {rd,sel} addresses.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 131;
  localparam int STALL_WS_BUS_WD = 39;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  typedef struct packed {
    logic        refill;
    logic [3:0]  s1_index;
    logic        s1_found;
    logic        tlbp;
    logic        tlbr;
    logic        tlbwi;
    logic        eret;
    logic [31:0] badvaddr;
    logic        bd;
    logic        has_ex;
    logic [4:0]  ex_type;
    logic        cp0_op;
    logic        cp0_we;
    logic [7:0]  cp0_addr;
    logic [1:0]  ls_off;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // Address-type exceptions are the only ones that latch BadVAddr.
  function automatic logic sets_badvaddr(input logic [4:0] code);
    return code inside {EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES};
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare, Count tick, read mux, interrupt pending.
// TIMER_INT_EN enables Cause.TI (Count==Compare) feeding IP7; otherwise TI reads as 0.
module cp0_regfile
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  i_hw_int,
  input  logic        i_ex,
  input  logic        i_ex_bd,
  input  logic [31:0] i_ex_pc,
  input  logic [4:0]  i_ex_code,
  input  logic [31:0] i_ex_badvaddr,
  input  logic        i_eret,
  input  logic        i_mtc0,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_epc,
  output logic        o_exl,
  output logic        o_int_pending
);

  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tick;
  logic        w_cause_ti;
  logic        w_wr_status, w_wr_cause, w_wr_epc, w_wr_count, w_wr_compare;
  logic [31:0] w_count_nx;
  logic [7:0]  w_ip;
  logic [31:0] w_status, w_cause;

  assign w_wr_status  = i_mtc0 && (i_addr == CP0_STATUS);
  assign w_wr_cause   = i_mtc0 && (i_addr == CP0_CAUSE);
  assign w_wr_epc     = i_mtc0 && (i_addr == CP0_EPC);
  assign w_wr_count   = i_mtc0 && (i_addr == CP0_COUNT);
  assign w_wr_compare = i_mtc0 && (i_addr == CP0_COMPARE);
  assign w_count_nx   = w_wr_count ? i_wdata : r_count + {31'b0, r_tick};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status_im  <= '0;
      r_status_exl <= 1'b0;
      r_status_ie  <= 1'b0;
    end else if (i_ex) begin
      r_status_exl <= 1'b1;
    end else begin
      if (w_wr_status) begin
        r_status_im  <= i_wdata[15:8];
        r_status_exl <= i_wdata[1];
        r_status_ie  <= i_wdata[0];
      end
      if (i_eret) r_status_exl <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cause_bd    <= 1'b0;
      r_cause_ip_hw <= '0;
      r_cause_ip_sw <= '0;
      r_cause_exc   <= '0;
      r_epc         <= '0;
      r_badvaddr    <= '0;
    end else begin
      r_cause_ip_hw <= i_hw_int;
      if (i_ex) begin
        // A nested exception (EXL already set) keeps the original EPC and BD.
        if (!r_status_exl) begin
          r_epc      <= i_ex_bd ? i_ex_pc - 32'd4 : i_ex_pc;
          r_cause_bd <= i_ex_bd;
        end
        r_cause_exc <= i_ex_code;
        if (sets_badvaddr(i_ex_code)) r_badvaddr <= i_ex_badvaddr;
      end else begin
        if (w_wr_cause) r_cause_ip_sw <= i_wdata[1:0];
        if (w_wr_epc)   r_epc         <= i_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_compare <= '0;
    end else begin
      r_count <= w_count_nx;
      r_tick  <= w_wr_count ? 1'b0 : ~r_tick;
      if (w_wr_compare) r_compare <= i_wdata;
    end
  end

`ifdef TIMER_INT_EN
  logic r_cause_ti;
  always_ff @(posedge clk) begin
    if (reset)                          r_cause_ti <= 1'b0;
    else if (w_wr_compare)              r_cause_ti <= 1'b0;
    else if (w_count_nx == r_compare)   r_cause_ti <= 1'b1;
  end
  assign w_cause_ti = r_cause_ti;
`else
  assign w_cause_ti = 1'b0;
`endif

  assign w_ip     = {r_cause_ip_hw[5] | w_cause_ti, r_cause_ip_hw[4:0], r_cause_ip_sw};
  assign w_status = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0, r_status_exl, r_status_ie};
  assign w_cause  = {r_cause_bd, w_cause_ti, 14'b0, w_ip, 1'b0, r_cause_exc, 2'b0};

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CP0_STATUS:   o_rdata = w_status;
      CP0_CAUSE:    o_rdata = w_cause;
      CP0_EPC:      o_rdata = r_epc;
      CP0_BADVADDR: o_rdata = r_badvaddr;
      CP0_COUNT:    o_rdata = r_count;
      CP0_COMPARE:  o_rdata = r_compare;
      default:      o_rdata = '0;
    endcase
  end

  assign o_epc         = r_epc;
  assign o_exl         = r_status_exl;
  assign o_int_pending = (|(w_ip & r_status_im)) & r_status_ie & ~r_status_exl;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR writes, raises exception/ERET/TLB-op pulses and drives redirect.
// Build option TIMER_INT_EN enables the Count/Compare timer interrupt in cp0_regfile.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_VEC_GENERAL = 32'hBFC0_0380,
  parameter logic [31:0] EX_VEC_REFILL  = 32'hBFC0_0200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  input  logic [5:0]                 hw_int,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [STALL_WS_BUS_WD-1:0] stall_ws_bus,
  output logic                       ws_ex,
  output logic                       ws_eret,
  output logic [2:0]                 ws_tlb_op,
  output logic [31:0]                ws_new_pc,
  output logic                       int_pending,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  logic        r_ws_valid;
  ms_to_ws_t   r_bus;
  logic        w_ws_ready_go;
  logic        w_no_ex;
  logic        w_mtc0;
  logic        w_mfc0;
  logic [31:0] w_cp0_rdata;
  logic [31:0] w_epc;
  logic        w_exl;
  logic        w_unused_bus;

  assign w_ws_ready_go = 1'b1;
  assign ws_allowin    = !r_ws_valid || w_ws_ready_go;

  // A committing exception/ERET also kills whatever the memory stage offers this cycle.
  always_ff @(posedge clk) begin
    if (reset)                  r_ws_valid <= 1'b0;
    else if (ws_ex || ws_eret)  r_ws_valid <= 1'b0;
    else if (ws_allowin)        r_ws_valid <= ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) r_bus <= ms_to_ws_bus;
  end

  assign w_no_ex = r_ws_valid && !r_bus.has_ex;
  assign ws_ex   = r_ws_valid && r_bus.has_ex;
  assign ws_eret = w_no_ex && r_bus.eret;
  assign w_mtc0  = w_no_ex && r_bus.cp0_we;
  assign w_mfc0  = r_bus.cp0_op && !r_bus.cp0_we;

  cp0_regfile u_cp0 (
    .clk           (clk),
    .reset         (reset),
    .i_hw_int      (hw_int),
    .i_ex          (ws_ex),
    .i_ex_bd       (r_bus.bd),
    .i_ex_pc       (r_bus.pc),
    .i_ex_code     (r_bus.ex_type),
    .i_ex_badvaddr (r_bus.badvaddr),
    .i_eret        (ws_eret),
    .i_mtc0        (w_mtc0),
    .i_addr        (r_bus.cp0_addr),
    .i_wdata       (r_bus.result),
    .o_rdata       (w_cp0_rdata),
    .o_epc         (w_epc),
    .o_exl         (w_exl),
    .o_int_pending (int_pending)
  );

  assign rf_we     = w_no_ex && r_bus.gr_we;
  assign rf_waddr  = r_ws_valid ? r_bus.dest : '0;
  assign rf_wdata  = !r_ws_valid ? '0 : (w_mfc0 ? w_cp0_rdata : r_bus.result);
  assign ws_tlb_op = {3{w_no_ex}} & {r_bus.tlbp, r_bus.tlbr, r_bus.tlbwi};

  // Refill vector choice uses EXL as it was before this exception sets it.
  assign ws_new_pc = ws_ex   ? ((r_bus.refill && !w_exl) ? EX_VEC_REFILL : EX_VEC_GENERAL) :
                     ws_eret ? w_epc : '0;

  assign stall_ws_bus = {rf_we, r_ws_valid && r_bus.cp0_we, rf_wdata, rf_waddr};

  assign debug_wb_pc       = r_ws_valid ? r_bus.pc : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  assign w_unused_bus = ^{r_bus.ls_off, r_bus.s1_index, r_bus.s1_found};

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios then random traffic, checked every cycle against a reference model.
module tb_wb_stage;

  typedef struct packed {
    logic        refill;
    logic [3:0]  s1_index;
    logic        s1_found;
    logic        tlbp, tlbr, tlbwi, eret;
    logic [31:0] badvaddr;
    logic        bd, has_ex;
    logic [4:0]  ex_type;
    logic        cp0_op, cp0_we;
    logic [7:0]  cp0_addr;
    logic [1:0]  ls_off;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result, pc;
  } ins_t;

  localparam logic [7:0] A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;
  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58;
  localparam logic [7:0] ADDRS [7] = '{8'h60, 8'h68, 8'h70, 8'h40, 8'h48, 8'h58, 8'h00};
  localparam logic [4:0] CODES [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, ms_to_ws_valid, ws_allowin, rf_we, ws_ex, ws_eret, int_pending;
  logic [130:0] ms_to_ws_bus;
  logic [5:0]   hw_int;
  logic [4:0]   rf_waddr, debug_wb_rf_wnum;
  logic [31:0]  rf_wdata, ws_new_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [38:0]  stall_ws_bus;
  logic [2:0]   ws_tlb_op;
  logic [3:0]   debug_wb_rf_wen;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state (architectural view).
  logic        m_valid = 1'b0;
  ins_t        m_ins = '0;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv, m_cnt_base, m_cmp;
  int unsigned m_cnt_edges;

  wb_stage #(.EX_VEC_GENERAL(32'hBFC0_0380), .EX_VEC_REFILL(32'hBFC0_0200)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .hw_int(hw_int), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .stall_ws_bus(stall_ws_bus), .ws_ex(ws_ex), .ws_eret(ws_eret),
    .ws_tlb_op(ws_tlb_op), .ws_new_pc(ws_new_pc), .int_pending(int_pending),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [130:0] pack(input ins_t t);
    return {t.refill, t.s1_index, t.s1_found, t.tlbp, t.tlbr, t.tlbwi, t.eret, t.badvaddr,
            t.bd, t.has_ex, t.ex_type, t.cp0_op, t.cp0_we, t.cp0_addr, t.ls_off, t.gr_we,
            t.dest, t.result, t.pc};
  endfunction

  function automatic logic m_ti_vis();
`ifdef TIMER_INT_EN
    return m_ti;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_cnt_edges / 2);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = ({2'b00, m_hw} << 2) | {6'b0, m_sw};
    if (m_ti_vis()) ip[7] = 1'b1;
    return ip;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    r = '0;
    if (a == A_STATUS) r = 32'h0040_0000 | ({24'b0, m_im} << 8) | {30'b0, m_exl, m_ie};
    else if (a == A_CAUSE) begin
      r[31] = m_bd; r[30] = m_ti_vis(); r[15:8] = m_ip(); r[6:2] = m_exc;
    end
    else if (a == A_EPC)   r = m_epc;
    else if (a == A_BADV)  r = m_badv;
    else if (a == A_COUNT) r = m_count();
    else if (a == A_CMP)   r = m_cmp;
    return r;
  endfunction

  task automatic model_update(input logic rst, input logic in_v, input ins_t t, input logic [5:0] hw);
    logic cmp_wr, cnt_wr;
    if (rst) begin
      m_valid = 0; m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_hw = '0; m_sw = '0;
      m_exc = '0; m_epc = '0; m_badv = '0; m_cnt_base = '0; m_cnt_edges = 0; m_cmp = '0;
      return;
    end
    cmp_wr = 0; cnt_wr = 0;
    if (m_valid && m_ins.has_ex) begin
      if (!m_exl) begin
        m_epc = m_ins.bd ? m_ins.pc - 32'd4 : m_ins.pc;
        m_bd  = m_ins.bd;
      end
      m_exc = m_ins.ex_type;
      m_exl = 1;
      if (m_ins.ex_type >= 5'd1 && m_ins.ex_type <= 5'd5) m_badv = m_ins.badvaddr;
    end else if (m_valid) begin
      if (m_ins.cp0_we) begin
        if (m_ins.cp0_addr == A_STATUS) begin
          m_im = m_ins.result[15:8]; m_exl = m_ins.result[1]; m_ie = m_ins.result[0];
        end
        else if (m_ins.cp0_addr == A_CAUSE) m_sw = m_ins.result[1:0];
        else if (m_ins.cp0_addr == A_EPC)   m_epc = m_ins.result;
        else if (m_ins.cp0_addr == A_COUNT) begin
          m_cnt_base = m_ins.result; m_cnt_edges = 0; cnt_wr = 1;
        end
        else if (m_ins.cp0_addr == A_CMP) begin
          m_cmp = m_ins.result; m_ti = 0; cmp_wr = 1;
        end
      end
      if (m_ins.eret) m_exl = 0;
    end
    if (!cnt_wr) m_cnt_edges++;
    if (!cmp_wr && m_count() == m_cmp) m_ti = 1;
    m_hw = hw;
    if (m_valid && (m_ins.has_ex || m_ins.eret)) m_valid = 0;
    else m_valid = in_v;
    if (in_v) m_ins = t;
  endtask

  task automatic check_all();
    logic v, nx, e_we, e_ex, e_eret;
    logic [31:0] e_wd, e_npc;
    logic [4:0] e_wa;
    v      = m_valid;
    nx     = v && !m_ins.has_ex;
    e_ex   = v && m_ins.has_ex;
    e_eret = nx && m_ins.eret;
    e_we   = nx && m_ins.gr_we;
    e_wa   = v ? m_ins.dest : 5'd0;
    e_wd   = !v ? 32'd0 : ((m_ins.cp0_op && !m_ins.cp0_we) ? m_read(m_ins.cp0_addr) : m_ins.result);
    e_npc  = e_ex ? ((m_ins.refill && !m_exl) ? 32'hBFC0_0200 : 32'hBFC0_0380) :
             e_eret ? m_epc : 32'd0;
    chk("allowin", ws_allowin, 1);
    chk("rf_we", rf_we, e_we);
    chk("rf_waddr", rf_waddr, e_wa);
    chk("rf_wdata", rf_wdata, e_wd);
    chk("ws_ex", ws_ex, e_ex);
    chk("ws_eret", ws_eret, e_eret);
    chk("ws_tlb_op", ws_tlb_op, nx ? {m_ins.tlbp, m_ins.tlbr, m_ins.tlbwi} : 3'b000);
    chk("ws_new_pc", ws_new_pc, e_npc);
    chk("int_pending", int_pending, (|(m_ip() & m_im)) && m_ie && !m_exl);
    chk("stall_ws_bus", stall_ws_bus, {e_we, v && m_ins.cp0_we, e_wd, e_wa});
    chk("dbg_pc", debug_wb_pc, v ? m_ins.pc : 32'd0);
    chk("dbg_wen", debug_wb_rf_wen, e_we ? 4'hF : 4'h0);
  endtask

  task automatic cyc(input logic rst, input logic v, input ins_t t, input logic [5:0] hw);
    reset = rst; ms_to_ws_valid = v; ms_to_ws_bus = pack(t); hw_int = hw;
    model_update(rst, v, t, hw);
    @(negedge clk);
    check_all();
  endtask

  function automatic ins_t i_alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    ins_t t = '0;
    t.pc = pc; t.dest = d; t.result = r; t.gr_we = 1;
    return t;
  endfunction

  function automatic ins_t i_mfc0(input logic [7:0] a);
    ins_t t = '0;
    t.pc = 32'hBFC0_2000; t.dest = 5'd9; t.gr_we = 1; t.cp0_op = 1; t.cp0_addr = a;
    return t;
  endfunction

  function automatic ins_t i_mtc0(input logic [7:0] a, input logic [31:0] d);
    ins_t t = '0;
    t.pc = 32'hBFC0_3000; t.cp0_op = 1; t.cp0_we = 1; t.cp0_addr = a; t.result = d;
    return t;
  endfunction

  function automatic ins_t i_exc(input logic [31:0] pc, input logic [4:0] c, input logic [31:0] bv,
                                 input logic bd, input logic refill);
    ins_t t = '0;
    t.pc = pc; t.has_ex = 1; t.ex_type = c; t.badvaddr = bv; t.bd = bd; t.refill = refill;
    t.gr_we = 1; t.dest = 5'd3; t.result = 32'hDEAD_0000;
    return t;
  endfunction

  function automatic ins_t i_eret();
    ins_t t = '0;
    t.pc = 32'hBFC0_4000; t.eret = 1;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int unsigned k;
    t = '0;
    k = $urandom_range(0, 9);
    t.pc = $urandom() & 32'hFFFF_FFFC; t.result = $urandom(); t.badvaddr = $urandom();
    t.dest = 5'($urandom()); t.ls_off = 2'($urandom()); t.s1_index = 4'($urandom());
    t.s1_found = 1'($urandom());
    if (k <= 3) t.gr_we = 1;
    else if (k <= 5) begin
      t.gr_we = 1; t.cp0_op = 1; t.cp0_addr = ADDRS[$urandom_range(0, 6)];
    end else if (k == 6) begin
      t.cp0_op = 1; t.cp0_we = 1; t.cp0_addr = ADDRS[$urandom_range(0, 6)];
    end else if (k == 7) begin
      t.has_ex = 1; t.ex_type = CODES[$urandom_range(0, 8)]; t.bd = 1'($urandom());
      t.refill = 1'($urandom()); t.gr_we = 1'($urandom()); t.cp0_we = 1'($urandom());
      t.cp0_op = t.cp0_we; t.cp0_addr = ADDRS[$urandom_range(0, 6)]; t.eret = 1'($urandom());
    end else if (k == 8) t.eret = 1;
    else {t.tlbp, t.tlbr, t.tlbwi} = 3'($urandom());
    return t;
  endfunction

  initial begin
    ins_t nop, t;
    logic [5:0] hw;
    nop = '0;
    // Reset state.
    cyc(1, 0, nop, 6'd0);
    cyc(1, 0, nop, 6'd0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_ws_ex", ws_ex, 0);
    cyc(0, 1, i_mfc0(A_STATUS), 6'd0);
    chk("rst_status", rf_wdata, 32'h0040_0000);

    // GPR write commits for exactly one cycle.
    cyc(0, 1, i_alu(32'hBFC0_0010, 5'd5, 32'h1234), 6'd0);
    chk("t1_rf_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    cyc(0, 0, nop, 6'd0);
    chk("t1_rf_we_drop", rf_we, 0);

    // Load address error.
    cyc(0, 1, i_exc(32'hBFC0_1000, 5'd4, 32'h3, 0, 0), 6'd0);
    chk("t2_ws_ex", ws_ex, 1);
    chk("t2_new_pc", ws_new_pc, 32'hBFC0_0380);
    chk("t2_rf_we", rf_we, 0);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_mfc0(A_EPC), 6'd0);
    chk("t2_epc", rf_wdata, 32'hBFC0_1000);
    cyc(0, 1, i_mfc0(A_CAUSE), 6'd0);
    chk("t2_exccode", rf_wdata[6:2], 5'd4);
    cyc(0, 1, i_mfc0(A_BADV), 6'd0);
    chk("t2_badv", rf_wdata, 32'h3);
    cyc(0, 1, i_mfc0(A_STATUS), 6'd0);
    chk("t2_exl", rf_wdata[1], 1);

    // ERET back to EPC.
    cyc(0, 1, i_eret(), 6'd0);
    chk("t4_eret", ws_eret, 1);
    chk("t4_new_pc", ws_new_pc, 32'hBFC0_1000);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_mfc0(A_STATUS), 6'd0);
    chk("t4_exl", rf_wdata[1], 0);

    // Delay-slot exception, then nested refill with EXL=1.
    cyc(0, 1, i_exc(32'h8000_0104, 5'd8, 32'h0, 1, 0), 6'd0);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_mfc0(A_EPC), 6'd0);
    chk("t3_epc_bd", rf_wdata, 32'h8000_0100);
    cyc(0, 1, i_mfc0(A_CAUSE), 6'd0);
    chk("t3_cause_bd", rf_wdata[31], 1);
    cyc(0, 1, i_exc(32'h8000_0200, 5'd2, 32'h1000, 0, 1), 6'd0);
    chk("t3_nested_vec", ws_new_pc, 32'hBFC0_0380);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_mfc0(A_EPC), 6'd0);
    chk("t3_epc_kept", rf_wdata, 32'h8000_0100);
    cyc(0, 1, i_eret(), 6'd0);
    chk("t3_eret_pc", ws_new_pc, 32'h8000_0100);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_exc(32'h8000_0300, 5'd3, 32'h2000, 0, 1), 6'd0);
    chk("refill_vec", ws_new_pc, 32'hBFC0_0200);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_eret(), 6'd0);
    cyc(0, 0, nop, 6'd0);

    // Exception beats mtc0 in the same instruction.
    t = i_exc(32'h8000_0400, 5'd12, 32'h0, 0, 0);
    t.cp0_op = 1; t.cp0_we = 1; t.cp0_addr = A_EPC; t.result = 32'hCAFE_F00C;
    cyc(0, 1, t, 6'd0);
    cyc(0, 0, nop, 6'd0);
    cyc(0, 1, i_mfc0(A_EPC), 6'd0);
    chk("ex_beats_mtc0", rf_wdata, 32'h8000_0400);
    cyc(0, 1, i_eret(), 6'd0);
    cyc(0, 0, nop, 6'd0);

    // TLB op pulse.
    t = nop; t.tlbp = 1;
    cyc(0, 1, t, 6'd0);
    chk("tlbp_pulse", ws_tlb_op, 3'b100);

    // Timer interrupt.
    cyc(0, 1, i_mtc0(A_COUNT, 32'd0), 6'd0);
    cyc(0, 1, i_mtc0(A_CMP, 32'd10), 6'd0);
    cyc(0, 1, i_mtc0(A_STATUS, 32'h0000_8001), 6'd0);
    for (int i = 0; i < 25; i++) cyc(0, 0, nop, 6'd0);
`ifdef TIMER_INT_EN
    chk("t5_int_up", int_pending, 1);
`else
    chk("t5_int_off", int_pending, 0);
`endif
    cyc(0, 1, i_mtc0(A_CMP, 32'd1000), 6'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, nop, 6'd0);
    chk("t5_int_clr", int_pending, 0);

    // Reset while an instruction is committing.
    cyc(0, 1, i_mtc0(A_STATUS, 32'h0000_FF03), 6'd0);
    cyc(1, 0, nop, 6'd0);
    chk("t6_rf_we", rf_we, 0);
    chk("t6_dbg_pc", debug_wb_pc, 0);
    cyc(0, 1, i_mfc0(A_STATUS), 6'd0);
    chk("t6_status", rf_wdata, 32'h0040_0000);

    // Random traffic.
    hw = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) hw = 6'($urandom());
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_ins(), hw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
